// File: rtl/req_arbiter8.sv
// rtl/req_arbiter8.sv - 8-requester arbiter with grant lock, fixed/round-robin priority and hold timeout
module req_arbiter8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       rr_mode,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       busy,
   output logic       timeout
);

   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t     r_state,   w_state_nxt;
   logic [7:0] r_gnt,     w_gnt_nxt;
   logic [2:0] r_gnt_id,  w_gnt_id_nxt;
   logic       r_busy,    w_busy_nxt;
   logic       r_timeout, w_timeout_nxt;
   logic [2:0] r_ptr,     w_ptr_nxt;
   logic [7:0] r_hcnt,    w_hcnt_nxt;

   logic [7:0] w_req_above;
   logic [2:0] w_win;

   // Lowest set bit wins; bit 0 has the highest priority.
   function automatic logic [2:0] lowest_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   // Winner: fixed priority, or round-robin search from ptr upward with wrap-around.
   always_comb begin
      w_req_above = req & (8'hFF << r_ptr);
      if (rr_mode && (w_req_above != 8'h00)) w_win = lowest_idx(w_req_above);
      else                                   w_win = lowest_idx(req);
   end

   // Next-state and next-output decision for IDLE/GRANT.
   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_gnt_id_nxt  = r_gnt_id;
      w_busy_nxt    = r_busy;
      w_timeout_nxt = 1'b0;
      w_ptr_nxt     = r_ptr;
      w_hcnt_nxt    = r_hcnt;
      case (r_state)
         S_IDLE: begin
            w_gnt_nxt  = 8'h00;
            w_busy_nxt = 1'b0;
            if (req != 8'h00) begin
               w_gnt_nxt    = 8'd1 << w_win;
               w_gnt_id_nxt = w_win;
               w_busy_nxt   = 1'b1;
               w_hcnt_nxt   = 8'd1;
               w_state_nxt  = S_GRANT;
            end
         end
         S_GRANT: begin
            // Release when the owner drops its request or the hold limit is reached.
            if (!req[r_gnt_id] || (r_hcnt == HOLD_MAX)) begin
               w_gnt_nxt     = 8'h00;
               w_busy_nxt    = 1'b0;
               w_hcnt_nxt    = 8'd0;
               w_ptr_nxt     = r_gnt_id + 3'd1;
               w_timeout_nxt = req[r_gnt_id];
               w_state_nxt   = S_IDLE;
            end else begin
               w_hcnt_nxt = r_hcnt + 8'd1;
            end
         end
      endcase
   end

   // State and registered outputs, cleared immediately on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_gnt     <= 8'h00;
         r_gnt_id  <= 3'd0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
         r_ptr     <= 3'd0;
         r_hcnt    <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_gnt_id  <= w_gnt_id_nxt;
         r_busy    <= w_busy_nxt;
         r_timeout <= w_timeout_nxt;
         r_ptr     <= w_ptr_nxt;
         r_hcnt    <= w_hcnt_nxt;
      end
   end

   assign gnt     = r_gnt;
   assign gnt_id  = r_gnt_id;
   assign busy    = r_busy;
   assign timeout = r_timeout;

endmodule

// File: tb/tb_req_arbiter8.sv
// tb/tb_req_arbiter8.sv - self-checking bench for req_arbiter8 with behavioural model
module tb_req_arbiter8;

   localparam int MAX_HOLD = 4;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic [7:0] req     = 8'h00;
   logic       rr_mode = 1'b0;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       busy;
   logic       timeout;

   int n_checks = 0;
   int n_errors = 0;

   // Model: owner index (-1 = nobody), cycles held, rr pointer, last id, timeout pulse.
   int   m_owner = -1;
   int   m_hold  = 0;
   int   m_ptr   = 0;
   int   m_id    = 0;
   logic m_to    = 1'b0;

   req_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .rr_mode (rr_mode),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [7:0] r, input logic rr, input int p);
      if (rr) begin
         for (int i = p; i < 8; i++) if (r[i]) return i;
      end
      for (int i = 0; i < 8; i++) if (r[i]) return i;
      return -1;
   endfunction

   // Model advances one arbitration step per rising edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner <= -1;
         m_hold  <= 0;
         m_ptr   <= 0;
         m_id    <= 0;
         m_to    <= 1'b0;
      end else begin
         m_to <= 1'b0;
         if (m_owner < 0) begin
            if (pick(req, rr_mode, m_ptr) >= 0) begin
               m_owner <= pick(req, rr_mode, m_ptr);
               m_id    <= pick(req, rr_mode, m_ptr);
               m_hold  <= 1;
            end
         end else if (!req[m_owner] || (m_hold == MAX_HOLD)) begin
            m_owner <= -1;
            m_ptr   <= (m_owner + 1) % 8;
            m_to    <= req[m_owner];
         end else begin
            m_hold <= m_hold + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   task automatic compare_model();
      logic [7:0] exp_gnt;
      exp_gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'h00;
      chk("model_gnt", gnt, exp_gnt);
      chk("model_gnt_id", {5'd0, gnt_id}, 8'(m_id));
      chk("model_busy", {7'd0, busy}, {7'd0, m_owner >= 0});
      chk("model_timeout", {7'd0, timeout}, {7'd0, m_to});
      chk("inv_onehot", {7'd0, $countones(gnt) <= 1}, 8'd1);
      chk("inv_busy_or", {7'd0, busy}, {7'd0, |gnt});
   endtask

   task automatic tick();
      @(negedge clk);
      compare_model();
   endtask

   task automatic rr_step(input logic [7:0] drop, input int exp_id);
      req = drop;
      tick();
      chk("rr_gap_gnt", gnt, 8'h00);
      req = 8'b1000_0101;
      tick();
      chk("rr_gnt_id", {5'd0, gnt_id}, 8'(exp_id));
      chk("rr_gnt", gnt, 8'd1 << exp_id);
   endtask

   initial begin
      tick();
      tick();
      chk("rst_gnt", gnt, 8'h00);
      chk("rst_gnt_id", {5'd0, gnt_id}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_timeout", {7'd0, timeout}, 8'd0);
      rst_n = 1'b1;
      tick();

      // Fixed priority
      req = 8'b1010_0100;
      tick();
      chk("fix_gnt", gnt, 8'b0000_0100);
      chk("fix_id", {5'd0, gnt_id}, 8'd2);
      chk("fix_busy", {7'd0, busy}, 8'd1);
      req = 8'b1010_0000;
      tick();
      chk("fix_gap_gnt", gnt, 8'h00);
      chk("fix_gap_id", {5'd0, gnt_id}, 8'd2);
      tick();
      chk("fix_gnt2", gnt, 8'b0010_0000);
      chk("fix_id2", {5'd0, gnt_id}, 8'd5);
      req = 8'h00;
      tick();

      // Round-robin with wrap
      rr_mode = 1'b1;
      req = 8'b0000_0100;
      tick();
      chk("rr_first_id", {5'd0, gnt_id}, 8'd2);
      req = 8'h00;
      tick();
      chk("rr_rel_gnt", gnt, 8'h00);
      req = 8'b0000_0101;
      tick();
      chk("rr_wrap_id", {5'd0, gnt_id}, 8'd0);
      chk("rr_wrap_gnt", gnt, 8'b0000_0001);
      rr_step(8'b1000_0100, 2);
      rr_step(8'b1000_0001, 7);
      rr_step(8'b0000_0101, 0);
      req = 8'h00;
      tick();
      rr_mode = 1'b0;

      // Hold timeout: 4 cycles granted, 1 gap cycle with timeout pulse, repeat
      req = 8'b0010_0000;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("to_gnt", gnt, ((k % 5) < 4) ? 8'b0010_0000 : 8'h00);
         chk("to_pulse", {7'd0, timeout}, {7'd0, (k % 5) == 4});
      end
      req = 8'h00;
      tick();
      tick();

      // Handoff, no preemption by bit 0
      req = 8'b0000_0010;
      tick();
      chk("ho_gnt", gnt, 8'b0000_0010);
      req = 8'b0000_0011;
      tick();
      chk("ho_nopreempt", gnt, 8'b0000_0010);
      req = 8'b0100_0000;
      tick();
      chk("ho_gap", gnt, 8'h00);
      tick();
      chk("ho_new_gnt", gnt, 8'b0100_0000);
      chk("ho_new_id", {5'd0, gnt_id}, 8'd6);
      req = 8'h00;
      tick();

      // Asynchronous reset mid-grant
      req = 8'h08;
      tick();
      chk("ar_pre_gnt", gnt, 8'b0000_1000);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_gnt", gnt, 8'h00);
      chk("ar_busy", {7'd0, busy}, 8'd0);
      chk("ar_id", {5'd0, gnt_id}, 8'd0);
      tick();
      rst_n   = 1'b1;
      rr_mode = 1'b1;
      req     = 8'b1000_1000;
      tick();
      chk("ar_regnt", gnt, 8'b0000_1000);
      chk("ar_regnt_id", {5'd0, gnt_id}, 8'd3);
      req = 8'h00;
      tick();
      rr_mode = 1'b0;

      // Idle
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("idle_gnt", gnt, 8'h00);
         chk("idle_busy", {7'd0, busy}, 8'd0);
         chk("idle_to", {7'd0, timeout}, 8'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/req_arbiter8.md
Name: req_arbiter8

Overview:
- Sequential 8-requester arbiter that shares one downstream resource among eight requesters.
- Winner selection uses the 8-to-3 priority-encoding rule: lowest set index wins, bit 0 highest priority.
- Adds a grant lock, selectable fixed or round-robin priority, a hold timeout with forced release, and a registered one-hot plus encoded grant.
- Sits between requester logic and a shared bus/resource mux; `gnt_id` drives the mux select directly.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one grant may be held before forced release. Legal range 2..255.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request vector, bit i = requester i, level-sensitive
- rr_mode  input  1  0 = fixed priority (bit 0 highest); 1 = round-robin; sampled only when an arbitration decision is made
- gnt  output  8  one-hot grant, registered; all zero when no grant
- gnt_id  output  3  encoded index of current/last grant, registered
- busy  output  1  high while in GRANT state
- timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Reset, asynchronous on rst_n low and effective immediately:
  - `gnt`=8'h00, `gnt_id`=3'd0, `busy`=0, `timeout`=0.
  - state=IDLE, rr pointer `ptr`=3'd0, hold counter `hcnt`=8'd0.
  - Reset deasserted mid-grant resumes from IDLE, with no grant carried over.
- States:
  - IDLE: no grant held.
  - GRANT: one requester owns the resource.
- IDLE:
  - If `req`==0: stay in IDLE, outputs unchanged except `gnt`=0, `busy`=0.
  - Else: choose winner W at the edge and, at that same edge:
    - `gnt`=1<<W, `gnt_id`=W, `busy`=1, `hcnt`=1
    - state → GRANT
  - Grant latency is therefore 1 cycle from `req` visible to `gnt` high.
- Winner selection:
  - Fixed mode: lowest set index of `req`.
  - RR mode: lowest set index i ≥ `ptr`; if none, lowest set index overall (wrap-around).
- GRANT, evaluated each edge, in priority order:
  1. `req[gnt_id]`==0 (normal release): `gnt`=0, `busy`=0, `hcnt`=0, `ptr`=`gnt_id`+1 mod 8, state → IDLE.
  2. `req[gnt_id]`==1 and `hcnt`==MAX_HOLD (forced release): same updates as normal release, plus `timeout`=1 for exactly one cycle.
  3. Otherwise: hold; `hcnt`=`hcnt`+1.
- Hold limit: `gnt` is high for at most MAX_HOLD consecutive cycles.
- Arbitration gap:
  - After any release `gnt` is 0 for at least one full cycle before the next grant; IDLE re-arbitrates on the following edge.
  - Release-to-next-grant is 2 edges.
- Requests during a grant:
  - Changes to other `req` bits while in GRANT are ignored; no preemption.
  - Dropping `req[gnt_id]` and raising another bit in the same cycle gives release first, then the new requester wins on the next edge.
- Fixed mode after timeout: the timed-out requester may win again after the gap cycle (it still holds lowest index). `timeout` pulses again on each expiry.
- `gnt_id` holds its last value in IDLE; consumers qualify it with `busy`.
- Invariants:
  - `gnt` is one-hot or zero.
  - `busy` == |`gnt`.
  - `timeout` is only ever high in the cycle after a GRANT→IDLE transition.
- `ptr` wraps: release of id 7 sets `ptr`=0.

Test Plan:
1. Fixed priority: rr_mode=0, `req`=8'b1010_0100 → one edge later `gnt`=8'b0000_0100, `gnt_id`=2, `busy`=1. Drop `req[2]` → `gnt`=0 for 1 cycle, then `gnt`=8'b0010_0000, `gnt_id`=5.
2. Round-robin wrap: rr_mode=1, grant id 2, then release → `ptr`=3. `req`=8'b0000_0101 → next grant `gnt_id`=0 (no bit ≥3, wraps). Then release with `req`=8'b1000_0101 → `gnt_id`=2, then 7, then 0.
3. Timeout: MAX_HOLD=4, `req`=8'b0010_0000 held constant → `gnt[5]` high exactly 4 cycles, `timeout`=1 for 1 cycle as `gnt` falls, `gnt`=0 one cycle, regrant id 5, repeat.
4. Handoff with new request: in GRANT id 1, same cycle `req` changes 8'b0000_0010→8'b0100_0000 → `gnt`=0 next cycle, then `gnt`=8'b0100_0000. No overlap and no preemption when bit 0 is raised mid-grant.
5. Async reset mid-grant: assert rst_n=0 between clock edges while `gnt`=8'b0000_1000 → `gnt`=0, `busy`=0, `gnt_id`=0 immediately. Release rst_n with `req`=8'h08 → regrant one edge later, `ptr` back to 0.
6. Idle: `req`=8'h00 for 20 cycles → `gnt`=0, `busy`=0, `timeout`=0 throughout; invariant checker (one-hot, `busy`==|`gnt`) on for all tests.
